// File: rtl/usb_term_pkg.sv
// Shared terminal-side constants, parser state encoding and the character
// classifier used by the hex line parser.
package usb_term_pkg;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_UA = 8'h41;
  localparam logic [7:0] CH_LA = 8'h61;

  // HI: waiting for the high nibble of a byte; LO: high nibble is held
  typedef enum logic {
    ST_HI = 1'b0,
    ST_LO = 1'b1
  } hex_state_e;

  typedef enum logic [1:0] {
    CC_HEX  = 2'd0,
    CC_SEP  = 2'd1,
    CC_TERM = 2'd2,
    CC_BAD  = 2'd3
  } char_class_e;

  typedef struct packed {
    char_class_e cls;
    logic [3:0]  nib;
  } char_info_t;

  // Classify one ASCII character; nib is only meaningful for CC_HEX
  function automatic char_info_t classify(input logic [7:0] c);
    char_info_t r;
    r.cls = CC_BAD;
    r.nib = 4'h0;
    if (c >= CH_0 && c <= (CH_0 + 8'd9)) begin
      r.cls = CC_HEX;
      r.nib = c[3:0];
    end else if ((c >= CH_UA && c <= (CH_UA + 8'd5)) ||
                 (c >= CH_LA && c <= (CH_LA + 8'd5))) begin
      // 'A'/'a' have low nibble 1, so value = low nibble + 9
      r.cls = CC_HEX;
      r.nib = c[3:0] + 4'd9;
    end else if (c == CH_SP) begin
      r.cls = CC_SEP;
    end else if (c == CH_CR || c == CH_LF) begin
      r.cls = CC_TERM;
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_hexparse_fifo.sv
// Decoded-byte FIFO. DEPTH must be a power of two (>= 2); pointers wrap
// naturally at their width. A push while full is accepted only when a pop
// happens in the same cycle, so the slot being read is the one rewritten.
module usb_hexparse_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero when empty so the output is clean after reset
  assign rdata   = empty ? 8'h00 : mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk48) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/usb_hexparse.sv
// ASCII hex line parser: turns pairs of hex digits from a terminal into
// bytes queued in a FIFO. Optional character echo is built when the macro
// HEXPARSE_ECHO_EN is defined.
//
// Output handshake: dout is valid while dout_v is high; a byte is consumed
// on a rising clk48 edge where dout_v and dout_rdy are both high, and dout
// holds its value for as long as dout_v is high and dout_rdy is low.
module usb_hexparse
  import usb_term_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_v,
  output logic [7:0] dout,
  output logic       dout_v,
  input  logic       dout_rdy,
  output logic       eol,
  output logic       err,
  output logic       ovf,
`ifdef HEXPARSE_ECHO_EN
  output logic [7:0] echo,
  output logic       echo_v,
`endif
  output hex_state_e dbg_state
);

  hex_state_e state, state_n;
  logic       din_v_q;
  logic       take;
  char_info_t ci;
  logic [3:0] hi_nib;
  logic       hi_ld;
  logic       push;
  logic       err_n;
  logic       eol_n;
  logic       pop;
  logic       full;
  logic       empty;

  assign take      = din_v && !din_v_q;
  assign ci        = classify(din);
  assign pop       = dout_v && dout_rdy;
  assign dout_v    = !empty;
  assign dbg_state = state;

  // Strobe edge detector; resets high so a strobe already up is not an edge
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) din_v_q <= 1'b1;
    else        din_v_q <= din_v;
  end

  // Parser next state and per-character actions
  always_comb begin
    state_n = state;
    hi_ld   = 1'b0;
    push    = 1'b0;
    err_n   = 1'b0;
    eol_n   = 1'b0;
    if (take) begin
      case (state)
        ST_HI: begin
          case (ci.cls)
            CC_HEX:  begin hi_ld = 1'b1; state_n = ST_LO; end
            CC_TERM: eol_n = 1'b1;
            CC_BAD:  err_n = 1'b1;
            default: ;
          endcase
        end
        ST_LO: begin
          state_n = ST_HI;
          case (ci.cls)
            CC_HEX:  push = 1'b1;
            CC_TERM: begin err_n = 1'b1; eol_n = 1'b1; end
            default: err_n = 1'b1;
          endcase
        end
        default: state_n = ST_HI;
      endcase
    end
  end

  // Parser state, held nibble and registered status pulses
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_HI;
      hi_nib <= 4'h0;
      eol    <= 1'b0;
      err    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_n;
      if (hi_ld) hi_nib <= ci.nib;
      eol <= eol_n;
      err <= err_n;
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  usb_hexparse_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk48 (clk48),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({hi_nib, ci.nib}),
    .pop   (pop),
    .rdata (dout),
    .full  (full),
    .empty (empty)
  );

`ifdef HEXPARSE_ECHO_EN
  // Echo accepted digits and separators; any terminator echoes as CR
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      echo   <= 8'h00;
      echo_v <= 1'b0;
    end else begin
      echo_v <= take && (ci.cls != CC_BAD);
      if (take && ci.cls != CC_BAD) echo <= (ci.cls == CC_TERM) ? CH_CR : din;
    end
  end
`endif

endmodule

// File: tb/tb_usb_hexparse.sv
// Self-checking bench for usb_hexparse (DEPTH = 16).
module tb_usb_hexparse;
  import usb_term_pkg::*;

  logic       clk48 = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_v;
  logic [7:0] dout;
  logic       dout_v;
  logic       dout_rdy;
  logic       eol;
  logic       err;
  logic       ovf;
  hex_state_e dbg_state;
`ifdef HEXPARSE_ECHO_EN
  logic [7:0] echo;
  logic       echo_v;
`endif

  usb_hexparse #(.DEPTH(16)) dut (
    .clk48     (clk48),
    .rst_n     (rst_n),
    .din       (din),
    .din_v     (din_v),
    .dout      (dout),
    .dout_v    (dout_v),
    .dout_rdy  (dout_rdy),
    .eol       (eol),
    .err       (err),
    .ovf       (ovf),
`ifdef HEXPARSE_ECHO_EN
    .echo      (echo),
    .echo_v    (echo_v),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #10 clk48 = ~clk48;

  int n_tests = 0;
  int n_fail  = 0;
  int eol_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard / monitor: sampled on the falling edge
  always @(negedge clk48) begin
    if (rst_n === 1'b1) begin
      if (eol) eol_cnt++;
      if (err) err_cnt++;
      if (eol && err) both_cnt++;
      if (dout_v && dout_rdy) begin
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else                   check("dout", dout, exp_q.pop_front());
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk48);
      #1;
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    din   = c;
    din_v = 1'b1;
    tick();
    din_v = 1'b0;
    tick();
  endtask

  task automatic send_str(input string s);
    foreach (s[i]) send_char(s[i]);
  endtask

  function automatic logic [7:0] hexchar(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lower ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    send_char(hexchar(b[7:4], b[0]));
    send_char(hexchar(b[3:0], b[1]));
  endtask

  task automatic drain(input string tag);
    int budget;
    budget   = 200;
    dout_rdy = 1'b1;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    tick(2);
    check({tag, "_empty"}, dout_v, 1'b0);
    dout_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    exp_q.delete();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0, b0;
    logic [7:0] b;

    rst_n    = 1'b0;
    din      = 8'h00;
    din_v    = 1'b0;
    dout_rdy = 1'b0;
    #5;
    check("rst_dout_v", dout_v, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_eol", eol, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_state", dbg_state, ST_HI);
    tick(2);
    rst_n = 1'b1;
    tick();

    // "3F A0\r"
    e0 = eol_cnt; r0 = err_cnt;
    exp_q.push_back(8'h3F);
    exp_q.push_back(8'hA0);
    dout_rdy = 1'b1;
    send_str("3F A0\r");
    drain("t1");
    check("t1_eol_count", eol_cnt - e0, 1);
    check("t1_err_count", err_cnt - r0, 0);

    // push-to-valid latency of one cycle
    send_char("5");
    din   = "a";
    din_v = 1'b1;
    @(negedge clk48);
    check("lat_before", dout_v, 1'b0);
    @(negedge clk48);
    check("lat_after", dout_v, 1'b1);
    check("lat_data", dout, 8'h5A);
    tick();
    din_v = 1'b0;
    tick();
    exp_q.push_back(8'h5A);
    drain("lat");

    // "b\r": terminator while a nibble is held
    e0 = eol_cnt; r0 = err_cnt; b0 = both_cnt;
    dout_rdy = 1'b1;
    send_str("b\r");
    tick(2);
    check("t2_both", both_cnt - b0, 1);
    check("t2_err", err_cnt - r0, 1);
    check("t2_eol", eol_cnt - e0, 1);
    check("t2_state", dbg_state, ST_HI);
    check("t2_nopush", dout_v, 1'b0);
    dout_rdy = 1'b0;

    // "1G" then "22"
    r0 = err_cnt;
    send_str("1G");
    tick();
    check("t3_err", err_cnt - r0, 1);
    check("t3_empty", dout_v, 1'b0);
    check("t3_state", dbg_state, ST_HI);
    exp_q.push_back(8'h22);
    send_str("22");
    drain("t3");

    // overflow: 17 bytes into 16 slots with no consumer
    dout_rdy = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'(i * 13 + 5);
      if (i < 16) exp_q.push_back(b);
      if (i == 16) check("t4_ovf_pre", ovf, 1'b0);
      send_byte(b);
    end
    check("t4_ovf", ovf, 1'b1);
    drain("t4");
    check("t4_ovf_sticky", ovf, 1'b1);
    do_reset();
    check("t4_ovf_rst", ovf, 1'b0);

    // full FIFO with a pop in the same cycle as the 17th push
    for (int i = 0; i < 16; i++) begin
      b = 8'hC0 + 8'(i);
      exp_q.push_back(b);
      send_byte(b);
    end
    send_char("5");
    din      = "B";
    din_v    = 1'b1;
    dout_rdy = 1'b1;
    tick();
    dout_rdy = 1'b0;
    din_v    = 1'b0;
    tick();
    exp_q.push_back(8'h5B);
    check("t5_ovf", ovf, 1'b0);
    send_byte(8'h99);
    check("t5_full_again", ovf, 1'b1);
    drain("t5");
    do_reset();

    // strobe already high when reset releases
    rst_n = 1'b0;
    din   = "3";
    din_v = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(2);
    check("t6_no_edge", dbg_state, ST_HI);
    din_v = 1'b0;
    tick();

    // reset mid-line discards the held nibble
    send_char("7");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_state", dbg_state, ST_HI);
    exp_q.push_back(8'h7E);
    send_str("7E");
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_hexparse.md
USB_HEXPARSE -- requirements
Module: usb_hexparse

Interface
REQ-001 SHALL have parameter DEPTH, default 16, power-of-two depth of the decoded-byte FIFO (minimum 2).
REQ-002 SHALL have port clk48  in  1  the only clock (48 MHz); all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port din  in  8  ASCII character from the terminal receiver.
REQ-005 SHALL have port din_v  in  1  level strobe; each 0->1 transition delivers exactly one character on din.
REQ-006 SHALL have port dout  out  8  decoded byte at the FIFO head.
REQ-007 SHALL have port dout_v  out  1  high while the FIFO is non-empty.
REQ-008 SHALL have port dout_rdy  in  1  consumer accept; pops when dout_v and dout_rdy are both high.
REQ-009 SHALL have port eol  out  1  one-cycle pulse on an accepted line terminator.
REQ-010 SHALL have port err  out  1  one-cycle pulse on a malformed character.
REQ-011 SHALL have port ovf  out  1  sticky; set when a byte is dropped because the FIFO is full.

Function
REQ-012 SHALL register din_v and detect rising edges; a character is taken in the cycle its edge is seen; din is ignored at all other times.
REQ-013 SHALL classify characters: '0'-'9' -> 0-9; 'A'-'F' and 'a'-'f' -> 10-15; space (0x20) -> separator; CR (0x0D) or LF (0x0A) -> terminator; anything else -> invalid.
REQ-014 SHALL implement two states: HI (awaiting high nibble; reset state) and LO (high nibble held).
REQ-015 In HI: a hex digit latches the high nibble and moves to LO; a separator is ignored; a terminator pulses eol; an invalid character pulses err; in each non-digit case the state stays HI.
REQ-016 In LO: a hex digit forms {high,low}, pushes it, and moves to HI; a separator, terminator, or invalid character pulses err, discards the held nibble, and moves to HI.
REQ-017 A terminator received in LO SHALL pulse both err and eol in the same cycle.
REQ-018 A push SHALL occur at the end of the cycle in which the second digit is taken; dout_v SHALL be high in the following cycle (latency 1).
REQ-019 A push while the FIFO is full and no pop occurs in that cycle SHALL drop the byte and set ovf; the FIFO contents SHALL be unchanged.
REQ-020 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full; the occupancy SHALL stay unchanged.
REQ-021 The FIFO occupancy counter SHALL be log2(DEPTH)+1 bits wide; the read and write pointers SHALL wrap modulo DEPTH.
REQ-022 dout SHALL be stable while dout_v is high and dout_rdy is low.
REQ-023 ovf SHALL clear only on reset.

Reset
REQ-024 Asserting rst_n low SHALL asynchronously set: state HI, FIFO empty, dout_v 0, dout 0x00, eol 0, err 0, ovf 0, and the registered copy of din_v to 1, so that a din_v already high at release is not taken as an edge.
REQ-025 Reset mid-line SHALL discard any held nibble and all FIFO contents.

Configuration
REQ-026 When HEXPARSE_ECHO_EN is defined, SHALL add ports echo (out, 8) and echo_v (out, 1).
REQ-027 With HEXPARSE_ECHO_EN, every accepted hex digit or separator SHALL be copied to echo with a one-cycle echo_v pulse in the cycle after its edge.
REQ-028 With HEXPARSE_ECHO_EN, a terminator SHALL echo as 0x0D and invalid characters SHALL not be echoed.
REQ-029 When HEXPARSE_ECHO_EN is not defined, the echo and echo_v ports and their logic SHALL be absent.

Structure
REQ-030 The ASCII constants (CR, LF, SP, '0', 'A', 'a') and the state encoding SHALL live in shared package usb_term_pkg.
REQ-031 The FIFO SHALL be the sub-module usb_hexparse_fifo (DEPTH parameter, push/pop/full/empty interface).

Verification
REQ-032 Bench SHALL send "3F A0\r" -> dout sequence 0x3F then 0xA0, eol pulses once, err never pulses.
REQ-033 Bench SHALL send "b\r" -> err and eol pulse in the same cycle, no byte is pushed, and the state returns to HI.
REQ-034 Bench SHALL send "1G" -> err pulses on 'G', the FIFO stays empty, and a following "22" yields 0x22.
REQ-035 Bench SHALL, with DEPTH=16 and dout_rdy=0, send 17 byte pairs -> 16 bytes held, ovf=1, and a drain yields the first 16 in order.
REQ-036 Bench SHALL, with the FIFO full and dout_rdy=1 in the cycle of the 17th push -> no drop, ovf stays 0, and occupancy stays 16.
REQ-037 Bench SHALL assert rst_n low after "7" -> after release, "7E" yields 0x7E, not 0x77.
